// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage for the single-cycle core. Fetches words from a multi-cycle
// instruction memory over a req/ack handshake and stores them in a small
// prefetch FIFO. The FIFO head goes to the core as {instr, instr_pc} with a
// valid/ready handshake. A redirect (taken branch, reset vector) flushes the
// FIFO and any fetch still in flight, then fetching restarts at the new address.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   imem_req     fetch request, held high until imem_ack
//   imem_addr    word-aligned fetch address, stable while imem_req=1
//   imem_ack     memory returns imem_rdata this cycle (only sampled with imem_req)
//   imem_rdata   instruction word returned with imem_ack
//   instr_valid  FIFO head valid
//   instr        FIFO head instruction (NOP_INSTR when empty)
//   instr_pc     address of instr (0 when empty)
//   instr_ready  core consumes the head when instr_valid & instr_ready
//   redirect     one-cycle pulse: flush and restart fetch at redirect_pc
//   redirect_pc  new fetch address, bits [1:0] forced to zero
//
// Optional build macro
//   IFU_PERF_EN  adds perf_fetched (words pushed into the FIFO) and
//                perf_flushed (words thrown away by a flush or a drained fetch).
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
`ifdef IFU_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  // IDLE : no request outstanding (FIFO full, waiting for room)
  // REQ  : request for fetch_pc outstanding
  // DRAIN: request for a pre-redirect address outstanding; its data is dropped
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      drain_addr_q, drain_addr_d;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_after;

  logic [31:0] pc_mem    [FIFO_DEPTH];
  logic [31:0] instr_mem [FIFO_DEPTH];

  logic [31:0] redir_pc;
  logic        ack_seen;
  logic        push;
  logic        pop;
  logic        discard;

  assign redir_pc    = redirect_pc & 32'hFFFF_FFFC;
  assign imem_req    = (state_q != S_IDLE);
  // While draining, fetch_pc already holds the redirect target, so the old
  // address has to be kept separately until the memory acknowledges it.
  assign imem_addr   = (state_q == S_DRAIN) ? drain_addr_q : fetch_pc_q;
  assign ack_seen    = imem_req & imem_ack;
  assign instr_valid = (count_q != '0);
  assign pop         = instr_valid & instr_ready;
  assign push        = (state_q == S_REQ) & ack_seen & ~redirect;
  assign count_after = count_q + CNT_W'(push) - CNT_W'(pop);

  assign instr    = instr_valid ? instr_mem[rd_ptr_q] : NOP_INSTR;
  assign instr_pc = instr_valid ? pc_mem[rd_ptr_q]    : 32'h0000_0000;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    drain_addr_d = drain_addr_q;
    discard      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (redirect) begin
          fetch_pc_d = redir_pc;
          state_d    = S_REQ;
        end else if (count_q < DEPTH_C) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (ack_seen) begin
          if (redirect) begin
            // Returned word belongs to the old path; drop it and refetch.
            discard    = 1'b1;
            fetch_pc_d = redir_pc;
            state_d    = S_REQ;
          end else begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = (count_after < DEPTH_C) ? S_REQ : S_IDLE;
          end
        end else if (redirect) begin
          drain_addr_d = fetch_pc_q;
          fetch_pc_d   = redir_pc;
          state_d      = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (redirect) begin
          fetch_pc_d = redir_pc;
        end
        if (ack_seen) begin
          discard = 1'b1;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge value of every other register, independent of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      fetch_pc_q   <= RESET_PC;
      drain_addr_q <= RESET_PC;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      drain_addr_q <= drain_addr_d;
    end
  end

  // A redirect flushes everything, including a head popped in the same cycle
  // (that pop still counts as consumed by the core).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (redirect) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_after;
    end
  end

  // NOTE: the FIFO storage has no reset; entries are only observable once
  // count_q says they were written, so resetting them would buy nothing.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= fetch_pc_q;
      instr_mem[wr_ptr_q] <= imem_rdata;
    end
  end

`ifdef IFU_PERF_EN
  logic [31:0] flushed_words;

  assign flushed_words = (redirect ? 32'(count_q - CNT_W'(pop)) : 32'd0) + 32'(discard);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched <= 32'd0;
      perf_flushed <= 32'd0;
    end else begin
      perf_fetched <= perf_fetched + 32'(push);
      perf_flushed <= perf_flushed + flushed_words;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Two fetch units: 'dut' (default parameters) driven by a programmable memory
// and core model, and 'dut_hi' (RESET_PC near the top of the address space)
// with a single-cycle memory and an always-ready core. The reference model is
// the program order itself: after reset or a redirect the core must see
// pc, pc+4, pc+8, ... (mod 2^32) with instr = rom(pc).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] HI_PC = 32'hFFFF_FFF8;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
`ifdef IFU_PERF_EN
  logic [31:0] perf_fetched, perf_flushed;
  logic [31:0] hi_perf_fetched, hi_perf_flushed;
`endif

  logic        hi_req, hi_ack, hi_valid;
  logic [31:0] hi_addr, hi_rdata, hi_instr, hi_pc;

  // memory model controls
  logic mem_auto;
  logic force_ack;
  int   mem_lat;
  int   wait_cnt;

  // scoreboard state
  int          tests;
  int          failed;
  int          n_consumed;
  logic [31:0] exp_pc;
  logic [31:0] last_pc;
  logic        pend_req;
  logic [31:0] pend_addr;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  instr_fetch_unit dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready),
    .redirect(redirect), .redirect_pc(redirect_pc)
`ifdef IFU_PERF_EN
    , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
  );

  instr_fetch_unit #(.RESET_PC(HI_PC)) dut_hi (
    .clk(clk), .reset(reset),
    .imem_req(hi_req), .imem_addr(hi_addr),
    .imem_ack(hi_ack), .imem_rdata(hi_rdata),
    .instr_valid(hi_valid), .instr(hi_instr), .instr_pc(hi_pc),
    .instr_ready(1'b1),
    .redirect(1'b0), .redirect_pc(32'h0000_0000)
`ifdef IFU_PERF_EN
    , .perf_fetched(hi_perf_fetched), .perf_flushed(hi_perf_flushed)
`endif
  );

  assign hi_ack   = hi_req;
  assign hi_rdata = rom(hi_addr);

  assign imem_ack   = imem_req && ((mem_auto && (wait_cnt >= mem_lat)) || force_ack);
  assign imem_rdata = imem_ack ? rom(imem_addr) : 32'hDEAD_DEAD;

  always @(posedge clk or negedge reset) begin
    if (!reset)                  wait_cnt <= 0;
    else if (!imem_req || imem_ack) wait_cnt <= 0;
    else                         wait_cnt <= wait_cnt + 1;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end

  // One clock cycle: sample at the falling edge, check handshake stability and
  // the consumed instruction stream, then return 1ns after the rising edge.
  task automatic step();
    @(negedge clk);
    if (pend_req) begin
      tests++;
      if (imem_req !== 1'b1 || imem_addr !== pend_addr) begin
        failed++;
        $display("FAIL req_hold: req=%b addr=%h, required req=1 addr=%h", imem_req, imem_addr, pend_addr);
      end
    end
    pend_req  = imem_req && !imem_ack;
    pend_addr = imem_addr;
    if (instr_valid) begin
      if (instr_ready) begin
        tests++;
        if (instr_pc !== exp_pc || instr !== rom(exp_pc)) begin
          failed++;
          $display("FAIL stream: pc=%h instr=%h, required pc=%h instr=%h", instr_pc, instr, exp_pc, rom(exp_pc));
        end
        last_pc = instr_pc;
        n_consumed++;
        exp_pc = exp_pc + 32'd4;
      end
    end else begin
      tests++;
      if (instr !== NOP || instr_pc !== 32'h0) begin
        failed++;
        $display("FAIL empty_outputs: instr=%h pc=%h, required instr=%h pc=0", instr, instr_pc, NOP);
      end
    end
    if (redirect) exp_pc = redirect_pc & 32'hFFFF_FFFC;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mem_auto    = 1'b0;
    force_ack   = 1'b0;
    mem_lat     = 0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_pc   = 32'h0;
    pend_req = 1'b0;
  endtask

  task automatic test_reset();
    mem_auto = 1'b0; force_ack = 1'b0; mem_lat = 0;
    instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    reset = 1'b0;
    #12;
    tests++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instr_valid !== 1'b0 ||
        instr !== NOP || instr_pc !== 32'h0) begin
      failed++;
      $display("FAIL reset_state: req=%b addr=%h valid=%b instr=%h pc=%h, required 0 0 0 %h 0",
               imem_req, imem_addr, instr_valid, instr, instr_pc, NOP);
    end
    tests++;
    if (hi_addr !== HI_PC || hi_req !== 1'b0) begin
      failed++;
      $display("FAIL reset_vector: addr=%h req=%b, required addr=%h req=0", hi_addr, hi_req, HI_PC);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests++;
    if (imem_req !== 1'b0) begin
      failed++;
      $display("FAIL req_before_edge: req=%b, required 0", imem_req);
    end
    @(posedge clk);
    #1;
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      failed++;
      $display("FAIL first_req: req=%b addr=%h, required req=1 addr=0", imem_req, imem_addr);
    end
    exp_pc = 32'h0; pend_req = 1'b0;
  endtask

  task automatic test_fetch_stream();
    int base;
    do_reset();
    instr_ready = 1'b1;
    mem_auto    = 1'b1;
    base = n_consumed;
    step();
    tests++;
    if (n_consumed != base) begin
      failed++;
      $display("FAIL ack_to_valid: consumed %0d in ack cycle, required 0", n_consumed - base);
    end
    base = n_consumed;
    repeat (20) step();
    tests++;
    if (n_consumed - base != 20) begin
      failed++;
      $display("FAIL throughput: %0d instructions in 20 cycles, required 20", n_consumed - base);
    end
  endtask

  task automatic test_backpressure();
    int  acks;
    bit  found;
    do_reset();
    mem_auto = 1'b1;
    mem_lat  = 1;
    acks     = 0;
    for (int i = 0; i < 15; i++) begin
      if (imem_req && imem_ack) acks++;
      step();
    end
    tests++;
    if (acks != 2) begin
      failed++;
      $display("FAIL full_pushes: %0d acks, required 2", acks);
    end
    tests++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
      failed++;
      $display("FAIL full_idle: req=%b valid=%b pc=%h, required req=0 valid=1 pc=0", imem_req, instr_valid, instr_pc);
    end
`ifdef IFU_PERF_EN
    tests++;
    if (perf_fetched !== 32'd2) begin
      failed++;
      $display("FAIL perf_fetched: %0d, required 2", perf_fetched);
    end
`endif
    instr_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (imem_req) found = 1'b1;
    end
    tests++;
    if (!found || imem_addr !== 32'h8) begin
      failed++;
      $display("FAIL resume_addr: req_seen=%b addr=%h, required req_seen=1 addr=8", found, imem_addr);
    end
    repeat (6) step();
  endtask

  task automatic test_redirect_drain();
    bit found;
    int base;
    do_reset();
    mem_auto = 1'b1;
    repeat (6) step();
    mem_auto    = 1'b0;
    instr_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (imem_req && imem_addr == 32'h8) found = 1'b1;
      else step();
    end
    tests++;
    if (!found) begin
      failed++;
      $display("FAIL wait_req8: req=%b addr=%h, required req=1 addr=8", imem_req, imem_addr);
    end
    redirect = 1'b1; redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      failed++;
      $display("FAIL drain_hold: req=%b addr=%h, required req=1 addr=8", imem_req, imem_addr);
    end
    repeat (3) step();
    mem_auto = 1'b1;
    step();
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      failed++;
      $display("FAIL drain_refetch: req=%b addr=%h, required req=1 addr=40", imem_req, imem_addr);
    end
    base = n_consumed;
    for (int i = 0; i < 10 && n_consumed == base; i++) step();
    tests++;
    if (n_consumed == base || last_pc !== 32'h40) begin
      failed++;
      $display("FAIL drain_first_pc: pc=%h, required 40", last_pc);
    end
  endtask

  task automatic test_redirect_with_ack();
    int base;
    instr_ready = 1'b1;
    mem_auto    = 1'b0;
    step();
    force_ack = 1'b1; redirect = 1'b1; redirect_pc = 32'h43;
    step();
    force_ack = 1'b0; redirect = 1'b0;
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h40 || instr_valid !== 1'b0) begin
      failed++;
      $display("FAIL ack_redirect: req=%b addr=%h valid=%b, required req=1 addr=40 valid=0", imem_req, imem_addr, instr_valid);
    end
    mem_auto = 1'b1;
    base = n_consumed;
    for (int i = 0; i < 10 && n_consumed == base; i++) step();
    tests++;
    if (n_consumed == base || last_pc !== 32'h40) begin
      failed++;
      $display("FAIL ack_redirect_pc: pc=%h, required 40", last_pc);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] pcs[$];
    logic [31:0] words[$];
    logic [31:0] want;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (hi_valid) begin
        pcs.push_back(hi_pc);
        words.push_back(hi_instr);
      end
    end
    @(posedge clk);
    #1;
    tests++;
    if (pcs.size() < 3) begin
      failed++;
      $display("FAIL wrap_count: %0d words, required at least 3", pcs.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        want = HI_PC + 32'(4 * i);
        tests++;
        if (pcs[i] !== want || words[i] !== rom(want)) begin
          failed++;
          $display("FAIL wrap_pc%0d: pc=%h instr=%h, required pc=%h instr=%h", i, pcs[i], words[i], want, rom(want));
        end
      end
    end
  endtask

  task automatic test_random();
    int base;
    do_reset();
    mem_auto = 1'b1;
    base = n_consumed;
    for (int i = 0; i < 800; i++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      mem_lat     = $urandom_range(0, 2);
      if ($urandom_range(0, 24) == 0) begin
        redirect    = 1'b1;
        redirect_pc = ($urandom_range(0, 1) != 0) ? $urandom : (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
      end
      step();
      redirect = 1'b0;
    end
    tests++;
    if (n_consumed - base < 100) begin
      failed++;
      $display("FAIL random_progress: %0d consumed, required at least 100", n_consumed - base);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    mem_auto = 1'b1;
    step();
    mem_auto = 1'b0;
    tests++;
    if (imem_req !== 1'b1 || instr_valid !== 1'b1) begin
      failed++;
      $display("FAIL pre_reset: req=%b valid=%b, required req=1 valid=1", imem_req, instr_valid);
    end
    #2;
    reset = 1'b0;
    #1;
    tests++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== NOP ||
        instr_pc !== 32'h0 || imem_addr !== 32'h0) begin
      failed++;
      $display("FAIL async_reset: req=%b valid=%b instr=%h pc=%h addr=%h, required 0 0 %h 0 0",
               imem_req, instr_valid, instr, instr_pc, imem_addr, NOP);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      failed++;
      $display("FAIL post_reset: valid=%b req=%b addr=%h, required valid=0 req=1 addr=0", instr_valid, imem_req, imem_addr);
    end
  endtask

  initial begin
    tests = 0; failed = 0; n_consumed = 0;
    exp_pc = 32'h0; last_pc = 32'h0; pend_req = 1'b0; pend_addr = 32'h0;
    reset = 1'b0;
    test_reset();
    test_fetch_stream();
    test_backpressure();
    test_redirect_drain();
    test_redirect_with_ack();
    test_wrap();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
